// File: rtl/cpu_defines.sv
// cpu_defines: shared fetch vectors, redirect priority encoding and PC FSM states
package cpu_defines;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hffff_fffc;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc0_0380;
  typedef enum logic [1:0] {PRIO_NONE = 2'd0, PRIO_BR = 2'd1, PRIO_ERET = 2'd2, PRIO_EXC = 2'd3} prio_e;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;
endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel: priority select between live exc/eret/br requests and a buffered redirect
// ports: exc_i/eret_i/br_i live requests, epc_i/br_target_i live targets,
//        pend_prio_i/pend_addr_i buffered redirect (PRIO_NONE when empty),
//        sel_prio_o/sel_addr_o winning priority and target (live wins ties)
module pc_redirect_sel
  import cpu_defines::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = EXC_VECTOR_DEF[WIDTH-1:0]
) (
  input  logic             exc_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             br_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  prio_e            pend_prio_i,
  input  logic [WIDTH-1:0] pend_addr_i,
  output prio_e            sel_prio_o,
  output logic [WIDTH-1:0] sel_addr_o
);
  prio_e            live_prio;
  logic [WIDTH-1:0] live_addr;
  logic             live_wins;
  always_comb begin
    live_prio = exc_i ? PRIO_EXC : eret_i ? PRIO_ERET : br_i ? PRIO_BR : PRIO_NONE;
    live_addr = exc_i ? EXC_VECTOR : eret_i ? epc_i : br_target_i;
    live_wins = live_prio >= pend_prio_i;
    sel_prio_o = live_wins ? live_prio : pend_prio_i;
    sel_addr_o = live_wins ? live_addr : pend_addr_i;
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with prioritised redirects and stall-safe redirect buffering
// ports: clk, rst (sync, active-low), en fetch advance, exc_req/eret_req+epc/br_req+br_target
//        redirect requests; pc fetch PC, pc_valid, redirected (last update was a redirect),
//        pc_misaligned (pc[1:0] != 0)
module pc_gen
  import cpu_defines::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF[WIDTH-1:0],
  parameter logic [WIDTH-1:0] EXC_VECTOR = EXC_VECTOR_DEF[WIDTH-1:0],
  parameter int INC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             redirected,
  output logic             pc_misaligned
);
  state_e           state_q, state_d;
  prio_e            pend_prio_q, pend_prio_d, sel_prio;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d, sel_addr, next_pc;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d, redir_q, redir_d, mis_q, mis_d, take;
  pc_redirect_sel #(.WIDTH(WIDTH), .EXC_VECTOR(EXC_VECTOR)) u_sel (
    .exc_i       (exc_req),
    .eret_i      (eret_req),
    .epc_i       (epc),
    .br_i        (br_req),
    .br_target_i (br_target),
    .pend_prio_i (state_q == PEND ? pend_prio_q : PRIO_NONE),
    .pend_addr_i (pend_addr_q),
    .sel_prio_o  (sel_prio),
    .sel_addr_o  (sel_addr)
  );
  always_comb begin
    take = sel_prio != PRIO_NONE;
    next_pc = take ? sel_addr : pc_q + WIDTH'(INC);
    pc_d = en ? next_pc : pc_q;
    valid_d = en | valid_q;
    redir_d = en ? take : redir_q;
    mis_d = en ? next_pc[1:0] != 2'b00 : mis_q;
    // while stalled the selector already folds live requests into the buffer with live-wins-tie
    state_d = en ? IDLE : take ? PEND : state_q;
    pend_prio_d = en ? PRIO_NONE : sel_prio;
    pend_addr_d = sel_addr;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_prio_q <= PRIO_NONE;
      pend_addr_q <= '0;
      pc_q <= RESET_VECTOR;
      valid_q <= 1'b0;
      redir_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_prio_q <= pend_prio_d;
      pend_addr_q <= pend_addr_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      redir_q <= redir_d;
      mis_q <= mis_d;
    end
  end
  assign pc = pc_q;
  assign pc_valid = valid_q;
  assign redirected = redir_q;
  assign pc_misaligned = mis_q;
endmodule
